// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction-fetch stage.
//               Holds the fetch FSM state encoding, the default reset vector
//               and the bubble instruction word placed in IF/ID when empty.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        REQ     = 2'd0,   // presenting a request to the instruction SRAM
        WAIT    = 2'd1,   // request accepted, waiting for read data
        HOLD    = 2'd2,   // data returned while ID stalled, parked in hold buffer
        DISCARD = 2'd3    // request in flight belongs to a flushed path
    } if_state_e;

    localparam logic [31:0] c_reset_pc = 32'hBFC0_0000;
    localparam logic [31:0] c_inst_nop = 32'h0000_0000;

endpackage : if_pkg
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : IF pipeline stage. Issues one instruction-SRAM request at a
//               time, fills the IF/ID register consumed by ID, honours MIPS
//               branch delay slots and takes exception/ERET redirects.
//               A 1-entry hold buffer absorbs a response arriving while ID
//               is stalled.
// Config      : IF_ADEL_CHECK_EN - when defined, a misaligned fetch PC does
//               not issue a request; a single address-error bubble (adel_o)
//               is delivered to IF/ID and fetch idles until the next flush.
//               When undefined adel_o is 0 and the address is word-aligned.
// Ports       : clk, rst              clock, synchronous active-high reset
//               stall_i               ID not consuming; IF/ID holds
//               flush_i, flush_pc_i   exception/ERET redirect (highest prio)
//               branch_flag_i,
//               branch_to_addr_i      taken branch in IF/ID and its target
//               inst_req_o, inst_addr_o, inst_addr_ok_i,
//               inst_data_ok_i, inst_rdata_i    SRAM request/response
//               valid_o, pc_o, inst_o,
//               is_in_delayslot_o, adel_o       IF/ID register to ID
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_to_addr_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        is_in_delayslot_o,
    output logic        adel_o
);

    if_state_e   r_state;
    if_state_e   w_state_nxt;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;      // address of the request currently in flight
    logic [31:0] r_br_target;
    logic        r_br_pend;
    logic        r_ds_next;     // next instruction entering IF/ID is a delay slot

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_ds;

    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_inst;
    logic        r_hold_ds;

    logic        w_misaligned;
    logic        w_load_adel;
    logic        w_addr_hs;
    logic        w_consume;
    logic        w_br_cap;
    logic        w_load_wait;
    logic        w_load_hold;
    logic        w_to_hold;
    logic        w_enter;
    logic [31:0] w_pc_plus4;

    assign w_addr_hs   = inst_req_o & inst_addr_ok_i;
    assign w_consume   = r_valid & ~stall_i;
    assign w_br_cap    = branch_flag_i & w_consume;
    assign w_load_wait = (r_state == WAIT) & inst_data_ok_i & (~stall_i | ~r_valid);
    assign w_to_hold   = (r_state == WAIT) & inst_data_ok_i & stall_i & r_valid;
    assign w_load_hold = (r_state == HOLD) & ~stall_i;
    // Any instruction (real, parked or error bubble) leaving the fetch path
    // toward IF/ID consumes the pending delay-slot marker.
    assign w_enter     = w_load_wait | w_load_hold | w_to_hold | w_load_adel;
    assign w_pc_plus4  = r_pc + 32'd4;

    assign inst_req_o  = (r_state == REQ) & ~w_misaligned;

`ifdef IF_ADEL_CHECK_EN
    logic r_adel;
    logic r_adel_sent;   // error bubble already delivered for this fetch PC

    assign w_misaligned = (r_fetch_pc[1:0] != 2'b00);
    assign w_load_adel  = (r_state == REQ) & w_misaligned & ~r_adel_sent
                        & (~stall_i | ~r_valid);
    assign inst_addr_o  = r_fetch_pc;
    assign adel_o       = r_adel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adel      <= 1'b0;
            r_adel_sent <= 1'b0;
        end else if (flush_i) begin
            r_adel      <= 1'b0;
            r_adel_sent <= 1'b0;
        end else if (w_load_adel) begin
            r_adel      <= 1'b1;
            r_adel_sent <= 1'b1;
        end else if (w_load_wait | w_load_hold | w_consume) begin
            r_adel      <= 1'b0;
        end
    end
`else
    assign w_misaligned = 1'b0;
    assign w_load_adel  = 1'b0;
    assign inst_addr_o  = {r_fetch_pc[31:2], 2'b00};
    assign adel_o       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic; flush overrides the normal transitions.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            REQ:     if (w_addr_hs)      w_state_nxt = WAIT;
            WAIT:    if (inst_data_ok_i) w_state_nxt = w_to_hold ? HOLD : REQ;
            HOLD:    if (~stall_i)       w_state_nxt = REQ;
            DISCARD: if (inst_data_ok_i) w_state_nxt = REQ;
        endcase
        if (flush_i) begin
            unique case (r_state)
                REQ:     w_state_nxt = w_addr_hs      ? DISCARD : REQ;
                WAIT:    w_state_nxt = inst_data_ok_i ? REQ     : DISCARD;
                HOLD:    w_state_nxt = REQ;
                DISCARD: w_state_nxt = inst_data_ok_i ? REQ     : DISCARD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= REQ;
            r_fetch_pc  <= RESET_PC;
            r_req_pc    <= 32'd0;
            r_br_target <= 32'd0;
            r_br_pend   <= 1'b0;
            r_ds_next   <= 1'b0;
            r_valid     <= 1'b0;
            r_pc        <= 32'd0;
            r_inst      <= c_inst_nop;
            r_ds        <= 1'b0;
            r_hold_pc   <= 32'd0;
            r_hold_inst <= c_inst_nop;
            r_hold_ds   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_addr_hs) begin
                r_req_pc <= inst_addr_o;
            end

            if (flush_i) begin
                r_fetch_pc <= flush_pc_i;
                r_br_pend  <= 1'b0;
                r_ds_next  <= 1'b0;
                r_valid    <= 1'b0;
                r_inst     <= c_inst_nop;
                r_ds       <= 1'b0;
                r_hold_ds  <= 1'b0;
            end else begin
                // Fetch PC: a branch seen while its delay slot has not been
                // requested yet is deferred until that request is accepted;
                // otherwise the target replaces the fall-through PC directly.
                if (w_br_cap) begin
                    if ((r_fetch_pc == w_pc_plus4) && ~w_addr_hs) begin
                        r_br_pend   <= 1'b1;
                        r_br_target <= branch_to_addr_i;
                    end else begin
                        r_fetch_pc  <= branch_to_addr_i;
                        r_br_pend   <= 1'b0;
                    end
                end else if (w_addr_hs) begin
                    r_fetch_pc <= r_br_pend ? r_br_target : (r_fetch_pc + 32'd4);
                    r_br_pend  <= 1'b0;
                end

                // When the delay slot enters in the same cycle as the branch
                // is consumed, it takes the marker directly.
                if (w_enter) begin
                    r_ds_next <= 1'b0;
                end else if (w_br_cap) begin
                    r_ds_next <= 1'b1;
                end

                if (w_to_hold) begin
                    r_hold_pc   <= r_req_pc;
                    r_hold_inst <= inst_rdata_i;
                    r_hold_ds   <= r_ds_next;
                end

                if (w_load_wait) begin
                    r_valid <= 1'b1;
                    r_pc    <= r_req_pc;
                    r_inst  <= inst_rdata_i;
                    r_ds    <= r_ds_next | w_br_cap;
                end else if (w_load_hold) begin
                    r_valid <= 1'b1;
                    r_pc    <= r_hold_pc;
                    r_inst  <= r_hold_inst;
                    r_ds    <= r_hold_ds | w_br_cap;
                end else if (w_load_adel) begin
                    r_valid <= 1'b1;
                    r_pc    <= r_fetch_pc;
                    r_inst  <= c_inst_nop;
                    r_ds    <= r_ds_next | w_br_cap;
                end else if (w_consume) begin
                    r_valid <= 1'b0;
                    r_inst  <= c_inst_nop;
                    r_ds    <= 1'b0;
                end
            end
        end
    end

    assign valid_o           = r_valid;
    assign pc_o              = r_pc;
    assign inst_o            = r_inst;
    assign is_in_delayslot_o = r_ds;

endmodule : inst_fetch
`default_nettype wire
